coreabc_iram_loader: RTL

Parametrised instruction RAM for the CoreABC controller: a single-port-clock, synchronous-read memory with a direct-addressed write path and an auto-incrementing streaming loader, plus an optional power-up clear sweep and an optional output pipeline register. It sits between the CoreABC instruction fetch (read side) and the boot/initialisation source (write side). It replaces the fixed 512x9 instruction store when wider, deeper or run-time-loaded program memory is needed.

---
 rtl/coreabc_iram_loader.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/coreabc_iram_loader.sv
// coreabc_iram_loader: instruction RAM for CoreABC with direct
// writes, an auto-incrementing stream loader and an optional clear sweep.
//
// Ports:
//   RWCLK      single clock, rising edge
//   RESET      synchronous active-high reset
//   RENABLE    read request; RADDR read address
//   RD         read data; RVALID pulses when RD updates
//   INITSTART  start a streaming load at INITADDR
//   INITADDR   direct write address or load base
//   INITDATA   write data; WENABLE write strobe
//   INITLAST   marks the final streamed word
//   INITBUSY   high while clearing or loading
//   INITDONE   high after a stream completes
//   INITERR    sticky overflow / wrap / out-of-range flag
module coreabc_iram_loader #(
   parameter int DWIDTH     = 9,
   parameter int AWIDTH     = 9,
   parameter int DEPTH      = 512,
   parameter int RD_PIPE    = 0,
   parameter int CLR_ON_RST = 0
) (
   input  logic              RWCLK,
   input  logic              RESET,
   input  logic              RENABLE,
   input  logic [AWIDTH-1:0] RADDR,
   output logic [DWIDTH-1:0] RD,
   output logic              RVALID,
   input  logic              INITSTART,
   input  logic [AWIDTH-1:0] INITADDR,
   input  logic [DWIDTH-1:0] INITDATA,
   input  logic              WENABLE,
   input  logic              INITLAST,
   output logic              INITBUSY,
   output logic              INITDONE,
   output logic              INITERR
);

   // Index width of the physical array; never wider than AWIDTH.
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [AWIDTH-1:0] ptr_q;
   logic [AWIDTH-1:0] ptr_d;
   logic              err_q;
   logic              err_d;

   logic              we;
   logic              we_g;
   logic [IW-1:0]     waddr;
   logic [DWIDTH-1:0] wdata;

   logic [DWIDTH-1:0] mem [DEPTH];

   logic              rd_en;
   logic [DWIDTH-1:0] rnew;
   logic [DWIDTH-1:0] rd0_q;
   logic              v0_q;

   function automatic logic in_rng(input logic [AWIDTH-1:0] a);
      return 32'(a) < 32'(DEPTH);
   endfunction

   function automatic logic is_last(input logic [AWIDTH-1:0] a);
      return 32'(a) == 32'(DEPTH - 1);
   endfunction

   // Pointer advance with wrap at DEPTH-1.
   function automatic logic [AWIDTH-1:0] nxt(input logic [AWIDTH-1:0] a);
      return is_last(a) ? '0 : a + AWIDTH'(1);
   endfunction

   // ---------------- state register ----------------
   always_ff @(posedge RWCLK) begin
      if (RESET) begin
         state_q <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
         ptr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_CLEAR: begin
            if (is_last(ptr_q))
               state_d = S_IDLE;
         end
         S_IDLE, S_DONE: begin
            if (INITSTART)
               state_d = S_LOAD;
         end
         S_LOAD: begin
            // A restart takes priority over completing the stream.
            if (!INITSTART && WENABLE && INITLAST)
               state_d = S_DONE;
         end
      endcase
   end

   // ---------------- output / datapath logic ----------------
   always_comb begin
      we       = 1'b0;
      waddr    = '0;
      wdata    = INITDATA;
      ptr_d    = ptr_q;
      err_d    = err_q;
      INITBUSY = (state_q == S_CLEAR) || (state_q == S_LOAD);
      INITDONE = (state_q == S_DONE);
      INITERR  = err_q;

      if (state_q == S_CLEAR) begin
         // Sweep: ptr doubles as the clear address.
         we    = 1'b1;
         waddr = ptr_q[IW-1:0];
         wdata = '0;
         ptr_d = ptr_q + AWIDTH'(1);
      end else if (INITSTART) begin
         err_d = 1'b0;
         if (!in_rng(INITADDR)) begin
            err_d = 1'b1;
            ptr_d = '0;
         end else if (WENABLE) begin
            we    = 1'b1;
            waddr = INITADDR[IW-1:0];
            ptr_d = nxt(INITADDR);
            if (is_last(INITADDR))
               err_d = 1'b1;
         end else begin
            ptr_d = INITADDR;
         end
      end else if (state_q == S_LOAD) begin
         if (WENABLE) begin
            we    = 1'b1;
            waddr = ptr_q[IW-1:0];
            ptr_d = nxt(ptr_q);
            if (is_last(ptr_q))
               err_d = 1'b1;
         end
      end else if (WENABLE) begin
         if (in_rng(INITADDR)) begin
            we    = 1'b1;
            waddr = INITADDR[IW-1:0];
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // ---------------- memory ----------------
   // Writes on a reset edge are dropped so reset aborts cleanly.
   assign we_g = we && !RESET;

   always_ff @(posedge RWCLK) begin
      if (we_g)
         mem[waddr] <= wdata;
   end

   // ---------------- read path ----------------
   assign rd_en = RENABLE && (state_q != S_CLEAR);

   // Write-first bypass for a same-edge read of the written word.
   always_comb begin
      rnew = '0;
      if (in_rng(RADDR)) begin
         if (we_g && (waddr == RADDR[IW-1:0]))
            rnew = wdata;
         else
            rnew = mem[RADDR[IW-1:0]];
      end
   end

   always_ff @(posedge RWCLK) begin
      if (RESET) begin
         rd0_q <= '0;
         v0_q  <= 1'b0;
      end else begin
         v0_q <= rd_en;
         if (rd_en)
            rd0_q <= rnew;
      end
   end

   generate
      if (RD_PIPE != 0) begin : g_pipe
         logic [DWIDTH-1:0] rd1_q;
         logic              v1_q;

         always_ff @(posedge RWCLK) begin
            if (RESET) begin
               rd1_q <= '0;
               v1_q  <= 1'b0;
            end else begin
               v1_q <= v0_q;
               if (v0_q)
                  rd1_q <= rd0_q;
            end
         end

         assign RD     = rd1_q;
         assign RVALID = v1_q;
      end else begin : g_nopipe
         assign RD     = rd0_q;
         assign RVALID = v0_q;
      end
   endgenerate

endmodule
